// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// datapath mux selects and the per-state control word.
package multicycle_control_fsm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR  = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWRITE = 4'd5, S_EXEC_R  = 4'd6,  S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,  S_BRANCH  = 4'd9,  S_JAL     = 4'd10, S_JALR    = 4'd11,
    S_JALR_WB = 4'd12, S_LUI     = 4'd13, S_TRAP    = 4'd14
  } state_t;

  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10} alu_src_a_t;
  typedef enum logic [1:0] {SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_t;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_t;
  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10, RES_IMMEXT = 2'b11
  } result_src_t;
  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_t;

  typedef struct packed {
    logic        mem_req;
    logic        adr_src;
    logic        fetch;
    logic        pc_update;
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_op_t     alu_op;
    result_src_t result_src;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    mem_req: 1'b0, adr_src: 1'b0, fetch: 1'b0, pc_update: 1'b0, reg_write: 1'b0,
    mem_write: 1'b0, branch: 1'b0, alu_src_a: SRCA_PC, alu_src_b: SRCB_RD2,
    alu_op: ALUOP_ADD, result_src: RES_ALUOUT
  };

  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control-sequencer <-> datapath/memory bundle; master is the sequencer side.
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCUpdate;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic       trap;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, AdrSrc, IRWrite, PCUpdate, PCWrite, RegWrite, MemWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, trap
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, AdrSrc, IRWrite, PCUpdate, PCWrite, RegWrite, MemWrite,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, trap
  );
endinterface

// File: rtl/multicycle_control_fsm_imm_src_decode.sv
// Immediate-format select derived combinationally from the opcode.
module multicycle_control_fsm_imm_src_decode
  import multicycle_control_fsm_pkg::*;
(
  input  logic [6:0] op,
  output imm_src_t   imm_src
);

  // Loads, OP-IMM and JALR share the I format, which is also the fallback.
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      OP_LUI:    imm_src = IMM_U;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multicycle RV32I core, with memory wait
// timeout and a sticky trap that only rst_n clears.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_fsm_if.master bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 32'd1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       trap_q, trap_d;
  logic       run_q;
  ctrl_t      ctrl_q, ctrl_d;
  logic       timeout_s;
  logic       pc_update_s;
  imm_src_t   imm_src_s;

  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.fetch = 1'b1; c.alu_src_b = SRCB_FOUR;
                        c.result_src = RES_ALURESULT; end
      S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
      S_MEMADR:   begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXEC_R:   begin c.alu_src_a = SRCA_RD1; c.alu_op = ALUOP_FUNCT; end
      S_EXEC_I:   begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH:   begin c.alu_src_a = SRCA_RD1; c.alu_op = ALUOP_SUB; c.branch = 1'b1; end
      // ALUOut still holds the DECODE target while the ALU forms OldPC+4 for rd.
      S_JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.pc_update = 1'b1; end
      S_JALR:     begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM;
                        c.result_src = RES_ALURESULT; c.pc_update = 1'b1; end
      S_JALR_WB:  begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
                        c.result_src = RES_ALURESULT; c.reg_write = 1'b1; end
      S_LUI:      begin c.result_src = RES_IMMEXT; c.reg_write = 1'b1; end
      default:    c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // Next state, wait counter, sticky trap and the control word for the next state.
  always_comb begin
    state_d   = state_q;
    timeout_s = !bus.mem_ready && (wait_cnt_q == WAIT_LAST);
    if (run_q) begin
      case (state_q)
        S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
                    else if (timeout_s) state_d = S_TRAP;
                    else state_d = S_FETCH;
        S_DECODE:
          case (bus.op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXEC_R;
            OP_IMM:            state_d = S_EXEC_I;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            default:           state_d = S_TRAP;
          endcase
        S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
                    else if (timeout_s) state_d = S_TRAP;
                    else state_d = S_MEMREAD;
        S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
                    else if (timeout_s) state_d = S_TRAP;
                    else state_d = S_MEMWRITE;
        S_EXEC_R, S_EXEC_I, S_JAL: state_d = S_ALUWB;
        S_JALR:     state_d = S_JALR_WB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JALR_WB, S_LUI: state_d = S_FETCH;
        default:    state_d = S_TRAP;
      endcase
    end else begin
      state_d = state_q;
    end

    if (state_d == S_TRAP) trap_d = 1'b1;
    else                   trap_d = trap_q;

    if (state_d != state_q) wait_cnt_d = 8'd0;
    else if (is_mem_wait(state_q) && !bus.mem_ready) wait_cnt_d = wait_cnt_q + 8'd1;
    else wait_cnt_d = wait_cnt_q;

    ctrl_d = ctrl_decode(state_d);
  end

  // State and registered control word; run_q keeps strobes off for one cycle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= 8'd0;
      trap_q     <= 1'b0;
      run_q      <= 1'b0;
      ctrl_q     <= CTRL_IDLE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      trap_q     <= trap_d;
      run_q      <= 1'b1;
      ctrl_q     <= ctrl_d;
    end
  end

  multicycle_control_fsm_imm_src_decode u_imm_src_decode (
    .op      (bus.op),
    .imm_src (imm_src_s)
  );

  // IR load and PC+4 happen only in the cycle the fetch completes.
  assign pc_update_s   = ctrl_q.pc_update | (ctrl_q.fetch & bus.mem_ready);
  assign bus.mem_req   = ctrl_q.mem_req;
  assign bus.AdrSrc    = ctrl_q.adr_src;
  assign bus.IRWrite   = ctrl_q.fetch & bus.mem_ready;
  assign bus.PCUpdate  = pc_update_s;
  assign bus.PCWrite   = pc_update_s | (ctrl_q.branch & bus.zero);
  assign bus.RegWrite  = ctrl_q.reg_write;
  assign bus.MemWrite  = ctrl_q.mem_write;
  assign bus.ALUSrcA   = ctrl_q.alu_src_a;
  assign bus.ALUSrcB   = ctrl_q.alu_src_b;
  assign bus.ALUOp     = ctrl_q.alu_op;
  assign bus.ResultSrc = ctrl_q.result_src;
  assign bus.ImmSrc    = imm_src_s;
  assign bus.trap      = trap_q;

endmodule
